// File: rtl/ucie_ctl_sb_tx_phase_sequencer.sv
// Sideband TX phase sequencer: splits a header (+ optional data) message into 32-bit
// phases and drives the NC-bit shift register, the RDI lp_cfg_vld qualifier and the RDI cfg credits.
module ucie_ctl_sb_tx_phase_sequencer #(
  parameter int NC      = 8,
  parameter int CRD_MAX = 4,
  parameter int GAP     = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_msg_valid,
  input  logic [63:0] i_msg_hdr,
  input  logic [63:0] i_msg_data,
  input  logic        i_msg_has_data,
  output logic        o_msg_ready,
  input  logic        i_rdi_pl_cfg_crd,
  output logic [1:0]  o_shift_load,
  output logic [31:0] o_phase_sent,
  input  logic        i_done_shift,
  output logic        o_rdi_lp_cfg_vld,
  output logic        o_err_protocol
);

  localparam int BEATS = 32 / NC;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CW    = $clog2(CRD_MAX + 1);

  localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);
  localparam logic [BW-1:0] DONE_BEAT = (NC < 32) ? BW'(BEATS - 2) : BW'(0);
  localparam logic [CW-1:0] CRD_FULL  = CW'(CRD_MAX);
  localparam logic [3:0]    GAP_LAST  = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    gap_q, gap_d;
  logic [CW-1:0] credit_q, credit_d;
  logic [63:0]   hdr_q, data_q;
  logic          has_data_q;
  logic          ready_q;
  logic [1:0]    shift_load_q;
  logic          vld_q;
  logic          err_q, err_d;
  logic          accept;
  logic [1:0]    last_idx;

  assign accept   = i_msg_valid & ready_q;
  assign last_idx = has_data_q ? 2'd3 : 2'd1;

  // Credit counter: simultaneous return and accept cancel; returns saturate at CRD_MAX.
  always_comb begin
    credit_d = credit_q;
    case ({i_rdi_pl_cfg_crd, accept})
      2'b10: begin
        if (credit_q != CRD_FULL) begin
          credit_d = credit_q + 1'b1;
        end else begin
          credit_d = credit_q;
        end
      end
      2'b01:   credit_d = credit_q - 1'b1;
      default: credit_d = credit_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    err_d   = err_q | ((state_q == ST_SHIFT) & (i_done_shift != (beat_q == DONE_BEAT)));
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_LOAD;
          idx_d   = 2'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        state_d = ST_SHIFT;
        beat_d  = '0;
      end
      ST_SHIFT: begin
        if (beat_q == BEAT_LAST) begin
          if (idx_q == last_idx) begin
            gap_d   = 4'd0;
            state_d = (GAP == 0) ? ST_IDLE : ST_GAP;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = ST_LOAD;
          end
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    case (idx_q)
      2'd0:    o_phase_sent = hdr_q[31:0];
      2'd1:    o_phase_sent = hdr_q[63:32];
      2'd2:    o_phase_sent = data_q[31:0];
      2'd3:    o_phase_sent = data_q[63:32];
      default: o_phase_sent = 32'd0;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state they describe.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q      <= ST_IDLE;
      beat_q       <= '0;
      idx_q        <= 2'd0;
      gap_q        <= 4'd0;
      credit_q     <= CRD_FULL;
      hdr_q        <= 64'd0;
      data_q       <= 64'd0;
      has_data_q   <= 1'b0;
      ready_q      <= 1'b0;
      shift_load_q <= 2'b00;
      vld_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      idx_q    <= idx_d;
      gap_q    <= gap_d;
      credit_q <= credit_d;
      err_q    <= err_d;
      ready_q  <= (state_d == ST_IDLE) && (credit_d != '0);
      vld_q    <= (state_d == ST_SHIFT);
      case (state_d)
        ST_LOAD:  shift_load_q <= 2'b01;
        ST_SHIFT: shift_load_q <= 2'b10;
        default:  shift_load_q <= 2'b00;
      endcase
      if (accept) begin
        hdr_q      <= i_msg_hdr;
        data_q     <= i_msg_has_data ? i_msg_data : 64'd0;
        has_data_q <= i_msg_has_data;
      end
    end
  end

  assign o_msg_ready      = ready_q;
  assign o_shift_load     = shift_load_q;
  assign o_rdi_lp_cfg_vld = vld_q;
  assign o_err_protocol   = err_q;

endmodule

// File: tb/tb_ucie_ctl_sb_tx_phase_sequencer.sv
// Bench for the sideband TX phase sequencer: three configurations, table vectors,
// directed corner sequences and randomized traffic against a cycle-count reference model.
module tb_ucie_ctl_sb_tx_phase_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // DUT A: NC=8, CRD_MAX=2, GAP=1
  localparam int BA = 4;
  localparam int GA = 1;
  localparam int CA = 2;
  logic        rst_a = 1'b0, va = 1'b0, hd_a = 1'b0, crd_a = 1'b0, rdy_a, vld_a, err_a, done_a;
  logic [63:0] hdr_a = 64'd0, data_a = 64'd0;
  logic [1:0]  sl_a;
  logic [31:0] ph_a;

  ucie_ctl_sb_tx_phase_sequencer #(.NC(8), .CRD_MAX(CA), .GAP(GA)) u_a (
    .i_clk(clk), .i_rst(rst_a), .i_msg_valid(va), .i_msg_hdr(hdr_a), .i_msg_data(data_a),
    .i_msg_has_data(hd_a), .o_msg_ready(rdy_a), .i_rdi_pl_cfg_crd(crd_a), .o_shift_load(sl_a),
    .o_phase_sent(ph_a), .i_done_shift(done_a), .o_rdi_lp_cfg_vld(vld_a), .o_err_protocol(err_a));

  // DUT B: NC=32, CRD_MAX=4, GAP=0
  logic        rst_b = 1'b0, vb = 1'b0, hd_b = 1'b0, crd_b = 1'b0, rdy_b, vld_b, err_b, done_b;
  logic [63:0] hdr_b = 64'd0, data_b = 64'd0;
  logic [1:0]  sl_b;
  logic [31:0] ph_b;

  ucie_ctl_sb_tx_phase_sequencer #(.NC(32), .CRD_MAX(4), .GAP(0)) u_b (
    .i_clk(clk), .i_rst(rst_b), .i_msg_valid(vb), .i_msg_hdr(hdr_b), .i_msg_data(data_b),
    .i_msg_has_data(hd_b), .o_msg_ready(rdy_b), .i_rdi_pl_cfg_crd(crd_b), .o_shift_load(sl_b),
    .o_phase_sent(ph_b), .i_done_shift(done_b), .o_rdi_lp_cfg_vld(vld_b), .o_err_protocol(err_b));

  // DUT C: NC=16, CRD_MAX=4, GAP=2, fed by a shift register that reports done one beat late
  logic        rst_c = 1'b0, vc = 1'b0, hd_c = 1'b0, crd_c = 1'b0, rdy_c, vld_c, err_c, done_c;
  logic [63:0] hdr_c = 64'd0, data_c = 64'd0;
  logic [1:0]  sl_c;
  logic [31:0] ph_c;

  ucie_ctl_sb_tx_phase_sequencer #(.NC(16), .CRD_MAX(4), .GAP(2)) u_c (
    .i_clk(clk), .i_rst(rst_c), .i_msg_valid(vc), .i_msg_hdr(hdr_c), .i_msg_data(data_c),
    .i_msg_has_data(hd_c), .o_msg_ready(rdy_c), .i_rdi_pl_cfg_crd(crd_c), .o_shift_load(sl_c),
    .o_phase_sent(ph_c), .i_done_shift(done_c), .o_rdi_lp_cfg_vld(vld_c), .o_err_protocol(err_c));

  // Shift-register environment models: count shifts since the last load, emit NC-bit chunks.
  int          cnt_a = 0, cnt_b = 0, cnt_c = 0;
  logic [31:0] sr_a = 32'd0;
  always @(posedge clk) begin
    if (sl_a == 2'b01) begin cnt_a <= 0; sr_a <= ph_a; end
    else if (sl_a == 2'b10) begin cnt_a <= cnt_a + 1; sr_a <= sr_a >> 8; end
    if (sl_b == 2'b01) cnt_b <= 0; else if (sl_b == 2'b10) cnt_b <= cnt_b + 1;
    if (sl_c == 2'b01) cnt_c <= 0; else if (sl_c == 2'b10) cnt_c <= cnt_c + 1;
  end
  assign done_a = (sl_a == 2'b10) && (cnt_a == BA - 2);
  assign done_b = (sl_b == 2'b10) && (cnt_b == 0);
  assign done_c = (sl_c == 2'b10) && (cnt_c == 1);
  logic [7:0] chunk_a;
  assign chunk_a = sr_a[7:0];

  // Reference model for DUT A: m_k counts cycles since accept (0 = idle).
  int          m_crd = CA, m_k = 0, m_last = 1, d_acc = 0;
  logic [31:0] m_ph [4];

  task automatic cyc_a(input logic v, input logic hd, input logic [63:0] h,
                       input logic [63:0] d, input logic c);
    int plen, o, p;
    logic [1:0] e_sl;
    logic e_vld, e_rdy, acc;
    @(negedge clk);
    plen  = (m_last + 1) * (1 + BA);
    e_rdy = (m_k == 0) && (m_crd != 0);
    e_sl  = 2'b00;
    e_vld = 1'b0;
    if (m_k >= 1 && m_k <= plen) begin
      o = (m_k - 1) % (1 + BA);
      p = (m_k - 1) / (1 + BA);
      e_sl  = (o == 0) ? 2'b01 : 2'b10;
      e_vld = (o != 0);
      chk("a_phase", ph_a, m_ph[p]);
    end
    chk("a_ready", rdy_a, e_rdy);
    chk("a_shift_load", sl_a, e_sl);
    chk("a_vld", vld_a, e_vld);
    chk("a_err", err_a, 1'b0);
    if (v && rdy_a) d_acc++;
    va = v; hd_a = hd; hdr_a = h; data_a = d; crd_a = c;
    acc = v && e_rdy;
    if (c && !acc && m_crd < CA) m_crd++;
    else if (acc && !c) m_crd--;
    if (acc) begin
      m_k = 1;
      m_last = hd ? 3 : 1;
      m_ph[0] = h[31:0]; m_ph[1] = h[63:32]; m_ph[2] = d[31:0]; m_ph[3] = d[63:32];
    end else if (m_k > 0) begin
      m_k++;
      if (m_k > plen + GA) m_k = 0;
    end
  endtask

  task automatic reset_a();
    @(negedge clk);
    rst_a = 1'b0; va = 1'b0; crd_a = 1'b0;
    @(negedge clk);
    chk("a_rst_ready", rdy_a, 1'b0);
    chk("a_rst_sl", sl_a, 2'b00);
    chk("a_rst_phase", ph_a, 32'd0);
    chk("a_rst_vld", vld_a, 1'b0);
    chk("a_rst_err", err_a, 1'b0);
    rst_a = 1'b1;
    m_k = 0; m_crd = CA; m_last = 1; d_acc = 0;
  endtask

  typedef struct {
    logic       v;
    logic [1:0] sl;
    logic       vld;
    logic [7:0] chunk;
    logic       rdy;
  } vec_t;
  vec_t tbl [13];

  logic [63:0] h1, h2, dd;
  logic [31:0] b_exp [4];

  initial begin
    tbl[0]  = '{1'b1, 2'b00, 1'b0, 8'h00, 1'b1};
    tbl[1]  = '{1'b0, 2'b01, 1'b0, 8'h00, 1'b0};
    tbl[2]  = '{1'b0, 2'b10, 1'b1, 8'hEF, 1'b0};
    tbl[3]  = '{1'b0, 2'b10, 1'b1, 8'hCD, 1'b0};
    tbl[4]  = '{1'b0, 2'b10, 1'b1, 8'hAB, 1'b0};
    tbl[5]  = '{1'b0, 2'b10, 1'b1, 8'h89, 1'b0};
    tbl[6]  = '{1'b0, 2'b01, 1'b0, 8'h00, 1'b0};
    tbl[7]  = '{1'b0, 2'b10, 1'b1, 8'h67, 1'b0};
    tbl[8]  = '{1'b0, 2'b10, 1'b1, 8'h45, 1'b0};
    tbl[9]  = '{1'b0, 2'b10, 1'b1, 8'h23, 1'b0};
    tbl[10] = '{1'b0, 2'b10, 1'b1, 8'h01, 1'b0};
    tbl[11] = '{1'b0, 2'b00, 1'b0, 8'h00, 1'b0};
    tbl[12] = '{1'b0, 2'b00, 1'b0, 8'h00, 1'b1};
    b_exp[0] = 32'h89ABCDEF; b_exp[1] = 32'h01234567;
    b_exp[2] = 32'hCAFEF00D; b_exp[3] = 32'hDEADBEEF;
    h1 = 64'h0123_4567_89AB_CDEF;

    repeat (2) @(negedge clk);
    rst_b = 1'b1; rst_c = 1'b1;

    // NC=8 two-phase packet: table of per-cycle outputs
    reset_a();
    for (int i = 0; i < 13; i++) begin
      cyc_a(tbl[i].v, 1'b0, h1, 64'd0, 1'b0);
      chk($sformatf("tbl_sl[%0d]", i), sl_a, tbl[i].sl);
      chk($sformatf("tbl_vld[%0d]", i), vld_a, tbl[i].vld);
      chk($sformatf("tbl_rdy[%0d]", i), rdy_a, tbl[i].rdy);
      if (tbl[i].vld) chk($sformatf("tbl_chunk[%0d]", i), chunk_a, tbl[i].chunk);
    end

    // Saturating return at full count, then credit exhaustion and recovery
    reset_a();
    cyc_a(1'b0, 1'b0, 64'd0, 64'd0, 1'b1);
    for (int i = 0; i < 40; i++) cyc_a(1'b1, 1'b0, {$urandom, $urandom}, 64'd0, 1'b0);
    chk("crd_two_accepts", d_acc, 2);
    chk("crd_blocked", rdy_a, 1'b0);
    cyc_a(1'b0, 1'b0, 64'd0, 64'd0, 1'b1);
    cyc_a(1'b1, 1'b0, h1, 64'd0, 1'b0);
    chk("crd_ready_after_pulse", rdy_a, 1'b1);
    chk("crd_third_accept", d_acc, 3);
    repeat (14) cyc_a(1'b1, 1'b0, h1, 64'd0, 1'b0);
    chk("crd_empty_again", d_acc, 3);

    // Return coinciding with accept at count=1 leaves the count at 1
    reset_a();
    cyc_a(1'b1, 1'b0, h1, 64'd0, 1'b0);
    repeat (12) cyc_a(1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
    cyc_a(1'b1, 1'b0, h1, 64'd0, 1'b1);
    repeat (12) cyc_a(1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
    chk("crd_coincide_ready", rdy_a, 1'b1);
    cyc_a(1'b1, 1'b0, h1, 64'd0, 1'b0);
    repeat (12) cyc_a(1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
    chk("crd_last_used", rdy_a, 1'b0);

    // Reset asserted mid-cycle during the second phase of a 4-phase packet
    reset_a();
    cyc_a(1'b1, 1'b1, h1, 64'hDEAD_BEEF_CAFE_F00D, 1'b0);
    repeat (7) cyc_a(1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
    @(posedge clk);
    #2 rst_a = 1'b0;
    #1;
    chk("midrst_ready", rdy_a, 1'b0);
    chk("midrst_sl", sl_a, 2'b00);
    chk("midrst_phase", ph_a, 32'd0);
    chk("midrst_vld", vld_a, 1'b0);
    chk("midrst_err", err_a, 1'b0);
    @(negedge clk);
    rst_a = 1'b1;
    m_k = 0; m_crd = CA; m_last = 1;
    h2 = 64'hFEDC_BA98_7654_3210;
    cyc_a(1'b1, 1'b0, h2, 64'd0, 1'b0);
    cyc_a(1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
    cyc_a(1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
    chk("midrst_first_chunk", chunk_a, h2[7:0]);
    repeat (12) cyc_a(1'b0, 1'b0, 64'd0, 64'd0, 1'b0);

    // Randomized traffic with sparse credit returns
    reset_a();
    for (int i = 0; i < 800; i++) begin
      dd = {$urandom, $urandom};
      cyc_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), {$urandom, $urandom}, dd,
            1'($urandom_range(0, 9) == 0));
    end

    // NC=32, 4-phase: one load and one shift per phase, GAP=0
    @(negedge clk);
    chk("b_ready_idle", rdy_b, 1'b1);
    vb = 1'b1; hd_b = 1'b1; hdr_b = h1; data_b = 64'hDEAD_BEEF_CAFE_F00D;
    @(negedge clk);
    vb = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("b_sl[%0d]", i), sl_b, (i % 2 == 0) ? 2'b01 : 2'b10);
      chk($sformatf("b_vld[%0d]", i), vld_b, (i % 2 == 1));
      chk($sformatf("b_phase[%0d]", i), ph_b, b_exp[i / 2]);
      chk($sformatf("b_ready[%0d]", i), rdy_b, 1'b0);
      @(negedge clk);
    end
    chk("b_ready_after", rdy_b, 1'b1);
    chk("b_err", err_b, 1'b0);

    // NC=16 with late done: sticky error from the first mismatching beat until reset
    @(negedge clk);
    vc = 1'b1; hd_c = 1'b0; hdr_c = {$urandom, $urandom};
    @(negedge clk);
    vc = 1'b0;
    chk("c_err_load", err_c, 1'b0);
    @(negedge clk);
    chk("c_err_first_shift", err_c, 1'b0);
    chk("c_vld_first_shift", vld_c, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("c_err_sticky[%0d]", i), err_c, 1'b1);
    end
    chk("c_ready_after", rdy_c, 1'b1);
    rst_c = 1'b0;
    #1 chk("c_err_reset", err_c, 1'b0);
    @(negedge clk);
    rst_c = 1'b1;
    @(negedge clk);
    chk("c_err_after_reset", err_c, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ucie_ctl_sb_tx_phase_sequencer.md
# ucie_ctl_sb_tx_phase_sequencer

Sideband TX stage that sits directly upstream of the NC-bit packet shift register. It accepts one sideband message (64-bit header plus optional 64-bit data) per handshake and splits it into 32-bit phases. It drives the shift register's load/shift control for each phase and generates the RDI `lp_cfg_vld` qualifier. It also enforces RDI config credits and an inter-packet idle gap, and cross-checks the shift register's `done_shift` indication.

## Interface
- NC, 8: RDI cfg width in bits; legal values 8, 16, 32. BEATS = 32/NC.
- CRD_MAX, 4: initial and maximum RDI cfg credit count.
- GAP, 1: idle cycles forced after the last beat of each packet; legal range 0..15.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset; one clock, asynchronous, active-low.
- i_msg_valid  in  1  a message is offered.
- i_msg_hdr  in  64  message header.
- i_msg_data  in  64  message payload; ignored when i_msg_has_data=0.
- i_msg_has_data  in  1  1 = 4-phase packet, 0 = 2-phase packet.
- o_msg_ready  out  1  sequencer can accept a message this cycle.
- i_rdi_pl_cfg_crd  in  1  one-cycle pulse returning one credit.
- o_shift_load  out  2  shift register control; MSB = shift, LSB = load. Values used: 00 hold, 01 load, 10 shift.
- o_phase_sent  out  32  phase presented to the shift register.
- i_done_shift  in  1  shift register's done indication.
- o_rdi_lp_cfg_vld  out  1  qualifies the NC-bit chunk on RDI lp_cfg.
- o_err_protocol  out  1  sticky flag; set when i_done_shift disagrees with the expected beat.

## Operation
- Phase order: hdr[31:0], hdr[63:32], data[31:0], data[63:32]. LAST = 3 if has_data, else 1.
- Accept: on i_msg_valid & o_msg_ready, register hdr, data and has_data; set phase_idx=0; decrement credit; go to LOAD.
- FSM states:
  - IDLE: o_msg_ready = (credit != 0). o_shift_load=00, vld=0.
  - LOAD: one cycle. o_shift_load=01, vld=0. Go to SHIFT with beat=0.
  - SHIFT: o_shift_load=10, vld=1, beat increments each cycle.
    - At beat==BEATS-1: if phase_idx==LAST, go to GAP (or to IDLE when GAP=0); otherwise increment phase_idx and go to LOAD.
  - GAP: o_shift_load=00, vld=0 for exactly GAP cycles, then go to IDLE.
- o_phase_sent = captured phase[phase_idx], combinational from registers. It is stable throughout LOAD and SHIFT.
- Expected done beat: DONE_BEAT = BEATS-2 for NC<32; DONE_BEAT = 0 for NC=32.
  - While in SHIFT, if i_done_shift != (beat==DONE_BEAT), set o_err_protocol.
  - i_done_shift is ignored outside SHIFT.
  - o_err_protocol clears only on reset.
- Credit counter:
  - Width $clog2(CRD_MAX+1). Reset value is CRD_MAX.
  - +1 on i_rdi_pl_cfg_crd; -1 on accept.
  - Return and accept in the same cycle leaves the count unchanged.
  - A return when the count is already CRD_MAX is dropped; the counter saturates.
  - Credit is consumed per packet, not per phase.
- A credit return never aborts or alters a packet in flight.
- Beat counter width $clog2(BEATS) (minimum 1). Gap counter is 4 bits.

## Timing
- Reset values: o_msg_ready=0 during reset and 1 after reset (CRD_MAX>0). o_shift_load=00, o_phase_sent=0, o_rdi_lp_cfg_vld=0, o_err_protocol=0. FSM is in IDLE.
- Reset asserted mid-packet: all state returns to IDLE immediately and the credit count returns to CRD_MAX. No partial beats are resumed.
- Accept at edge T: LOAD during cycle T+1; first valid chunk during T+2.
- Per phase: 1 LOAD cycle plus BEATS valid cycles. vld drops for one cycle between phases of the same packet.
- Packet length in cycles: (LAST+1)·(1+BEATS), then GAP idle cycles, then IDLE. o_msg_ready can rise at the earliest in the cycle after the gap.
  - NC=8, 2-phase, GAP=1: accept-to-ready = 12 cycles.
- o_msg_ready is low in LOAD, SHIFT and GAP. Back-to-back messages are therefore never accepted without the gap.
- Credit zero: o_msg_ready stays low. A credit pulse in cycle C makes o_msg_ready high in cycle C+1.

## Test plan
- NC=8, GAP=1, hdr=64'h0123_4567_89AB_CDEF, has_data=0 → vld-high chunks EF,CD,AB,89, a vld-low cycle, then 67,45,23,01. o_shift_load sequence: 01,10,10,10,10,01,10,10,10,10,00. Ready returns 12 cycles after accept.
- NC=32, has_data=1, data=64'hDEAD_BEEF_CAFE_F00D → o_phase_sent sequence 89ABCDEF, 01234567, CAFEF00D, DEADBEEF. Each phase has one 01 cycle then one 10 cycle. o_err_protocol stays 0 with a compliant shift-register model.
- CRD_MAX=2, no credit returns, 3 messages offered → 2 accepted; o_msg_ready stays 0. Pulse i_rdi_pl_cfg_crd once → third message accepted one cycle later.
- Credit return coinciding with accept at count=1 → count stays 1. Return at count=CRD_MAX → count stays CRD_MAX.
- Shift-register model asserts done one beat late (NC=16) → o_err_protocol rises on the first mismatching cycle and stays 1 until reset.
- Assert i_rst during the second phase of a packet → all outputs take reset values immediately. After release, a new message serializes normally starting from phase 0.
